rr_hazard_ctl: RTL and testbench

Issue controller for the register-read (RR) pipeline latch. Tracks in-flight writes to the eight GPRs and eight segment registers with per-register pending counters. Each cycle it decides whether the decoded instruction may enter the RR latch, inserts a bubble otherwise, and back-pressures decode. It sits between decode and the RR latch, driving the latch's `stall` input and its valid bit `in[0]`.

---
 rtl/rr_hazard_ctl.sv | 136 +++++++++++++
 tb/tb_rr_hazard_ctl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_hazard_ctl.sv
// Register-read issue controller: per-register pending-write counters gate decode into the RR latch.
// Optional RR_REL_BYPASS_EN lets a source whose last pending writer is releasing this cycle count as ready.
module rr_hazard_ctl #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_v,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  input  logic [2:0]        base,
  input  logic [2:0]        idx,
  input  logic              sr1_en,
  input  logic              sr2_en,
  input  logic              base_en,
  input  logic              idx_en,
  input  logic [2:0]        segr1,
  input  logic [2:0]        segr2,
  input  logic              segr1_en,
  input  logic              segr2_en,
  input  logic [2:0]        dst_gpr,
  input  logic              dst_gpr_we,
  input  logic [2:0]        dst_seg,
  input  logic              dst_seg_we,
  input  logic [2:0]        rel_gpr,
  input  logic              rel_gpr_v,
  input  logic [2:0]        rel_seg,
  input  logic              rel_seg_v,
  input  logic              ds_stall,
  input  logic              flush,
  output logic              rr_stall,
  output logic              rr_v_in,
  output logic              dec_stall,
  output logic              busy,
  output logic [PERF_W-1:0] hz_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  gcnt_q [8];
  logic [CNT_W-1:0]  gcnt_d [8];
  logic [CNT_W-1:0]  scnt_q [8];
  logic [CNT_W-1:0]  scnt_d [8];
  logic [PERF_W-1:0] hz_q, hz_d;
  logic              busy_q, busy_d;

  logic [7:0] g_wait, s_wait;
  logic [7:0] g_inc, g_dec, s_inc, s_dec;
  logic       src_hz, sat_hz, hazard, issue;

  always_comb begin
    g_wait = '0;
    s_wait = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      g_wait[i] = (gcnt_q[i] != '0);
      s_wait[i] = (scnt_q[i] != '0);
`ifdef RR_REL_BYPASS_EN
      if (rel_gpr_v && (rel_gpr == 3'(i)) && (gcnt_q[i] == CNT_ONE)) g_wait[i] = 1'b0;
      if (rel_seg_v && (rel_seg == 3'(i)) && (scnt_q[i] == CNT_ONE)) s_wait[i] = 1'b0;
`endif
    end
  end

  assign src_hz = (sr1_en   & g_wait[sr1])   | (sr2_en   & g_wait[sr2])  |
                  (base_en  & g_wait[base])  | (idx_en   & g_wait[idx])  |
                  (segr1_en & s_wait[segr1]) | (segr2_en & s_wait[segr2]);
  assign sat_hz = (dst_gpr_we & (gcnt_q[dst_gpr] == CNT_MAX)) |
                  (dst_seg_we & (scnt_q[dst_seg] == CNT_MAX));

  assign hazard    = d_v & (src_hz | sat_hz);
  assign issue     = d_v & ~hazard & ~ds_stall & ~flush;
  assign rr_stall  = ds_stall;
  assign rr_v_in   = issue;
  assign dec_stall = d_v & ~flush & (hazard | ds_stall);
  assign busy      = busy_q;
  assign hz_cnt    = hz_q;

  always_comb begin
    g_inc = '0;
    g_dec = '0;
    s_inc = '0;
    s_dec = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      g_inc[i] = issue & dst_gpr_we & (dst_gpr == 3'(i));
      g_dec[i] = rel_gpr_v & (rel_gpr == 3'(i));
      s_inc[i] = issue & dst_seg_we & (dst_seg == 3'(i));
      s_dec[i] = rel_seg_v & (rel_seg == 3'(i));
    end
  end

  // Releasing an empty counter holds it at zero; saturation blocks issue, so increments never wrap.
  always_comb begin
    busy_d = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      gcnt_d[i] = gcnt_q[i];
      scnt_d[i] = scnt_q[i];
      if (g_inc[i] && !g_dec[i])
        gcnt_d[i] = gcnt_q[i] + CNT_ONE;
      else if (!g_inc[i] && g_dec[i] && (gcnt_q[i] != '0))
        gcnt_d[i] = gcnt_q[i] - CNT_ONE;
      if (s_inc[i] && !s_dec[i])
        scnt_d[i] = scnt_q[i] + CNT_ONE;
      else if (!s_inc[i] && s_dec[i] && (scnt_q[i] != '0))
        scnt_d[i] = scnt_q[i] - CNT_ONE;
      busy_d = busy_d | (gcnt_d[i] != '0) | (scnt_d[i] != '0);
    end
  end

  always_comb begin
    hz_d = hz_q;
    if (hazard && !ds_stall && !flush && (hz_q != '1))
      hz_d = hz_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gcnt_q <= '{default: '0};
      scnt_q <= '{default: '0};
      hz_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      scnt_q <= scnt_d;
      hz_q   <= hz_d;
      busy_q <= busy_d;
    end
  end

  rel_gpr_nonzero: assert property (@(posedge clk) disable iff (!rst)
    rel_gpr_v |-> (gcnt_q[rel_gpr] != '0));
  rel_seg_nonzero: assert property (@(posedge clk) disable iff (!rst)
    rel_seg_v |-> (scnt_q[rel_seg] != '0));

endmodule

// File: tb/tb_rr_hazard_ctl.sv
// Bench for rr_hazard_ctl: integer pending-count model checked every cycle plus directed literal checks.
module tb_rr_hazard_ctl;

  localparam int HZMAX = 15;
  localparam int CMAX  = 3;
`ifdef RR_REL_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       d_v;
  logic [2:0] sr1, sr2, base, idx, segr1, segr2;
  logic       sr1_en, sr2_en, base_en, idx_en, segr1_en, segr2_en;
  logic [2:0] dst_gpr, dst_seg, rel_gpr, rel_seg;
  logic       dst_gpr_we, dst_seg_we, rel_gpr_v, rel_seg_v;
  logic       ds_stall, flush;
  logic       rr_stall, rr_v_in, dec_stall, busy;
  logic [3:0] hz_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int gm [8];
  int sm [8];
  int hzm;
  bit busym;

  always #5 clk = ~clk;

  rr_hazard_ctl #(.CNT_W(2), .PERF_W(4)) dut (
    .clk(clk), .rst(rst), .d_v(d_v),
    .sr1(sr1), .sr2(sr2), .base(base), .idx(idx),
    .sr1_en(sr1_en), .sr2_en(sr2_en), .base_en(base_en), .idx_en(idx_en),
    .segr1(segr1), .segr2(segr2), .segr1_en(segr1_en), .segr2_en(segr2_en),
    .dst_gpr(dst_gpr), .dst_gpr_we(dst_gpr_we), .dst_seg(dst_seg), .dst_seg_we(dst_seg_we),
    .rel_gpr(rel_gpr), .rel_gpr_v(rel_gpr_v), .rel_seg(rel_seg), .rel_seg_v(rel_seg_v),
    .ds_stall(ds_stall), .flush(flush),
    .rr_stall(rr_stall), .rr_v_in(rr_v_in), .dec_stall(dec_stall),
    .busy(busy), .hz_cnt(hz_cnt)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A register is "not ready" while writes are outstanding, unless bypass sees its last writer leaving now.
  function automatic bit gwait(int r);
    return (gm[r] > 0) && !(BYP == 1 && gm[r] == 1 && rel_gpr_v && int'(rel_gpr) == r);
  endfunction

  function automatic bit swait(int r);
    return (sm[r] > 0) && !(BYP == 1 && sm[r] == 1 && rel_seg_v && int'(rel_seg) == r);
  endfunction

  function automatic void model_comb(output bit hz, output bit iss);
    bit src, sat;
    src = (sr1_en && gwait(sr1)) || (sr2_en && gwait(sr2)) ||
          (base_en && gwait(base)) || (idx_en && gwait(idx)) ||
          (segr1_en && swait(segr1)) || (segr2_en && swait(segr2));
    sat = (dst_gpr_we && gm[dst_gpr] == CMAX) || (dst_seg_we && sm[dst_seg] == CMAX);
    hz  = d_v && (src || sat);
    iss = d_v && !hz && !ds_stall && !flush;
  endfunction

  always @(posedge clk) begin
    bit h, iss;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        gm[i] = 0;
        sm[i] = 0;
      end
      hzm   = 0;
      busym = 1'b0;
    end else begin
      model_comb(h, iss);
      if (iss && dst_gpr_we) gm[dst_gpr] = gm[dst_gpr] + 1;
      if (iss && dst_seg_we) sm[dst_seg] = sm[dst_seg] + 1;
      if (rel_gpr_v && gm[rel_gpr] > 0) gm[rel_gpr] = gm[rel_gpr] - 1;
      if (rel_seg_v && sm[rel_seg] > 0) sm[rel_seg] = sm[rel_seg] - 1;
      if (h && !ds_stall && !flush && hzm < HZMAX) hzm = hzm + 1;
      busym = 1'b0;
      for (int i = 0; i < 8; i++) if (gm[i] > 0 || sm[i] > 0) busym = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit h, iss;
    if (chk_en) begin
      model_comb(h, iss);
      cmp("m_rr_stall", rr_stall, ds_stall);
      cmp("m_rr_v_in", rr_v_in, iss);
      cmp("m_dec_stall", dec_stall, d_v && !flush && (h || ds_stall));
      cmp("m_busy", busy, busym);
      cmp("m_hz_cnt", hz_cnt, hzm);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_v = 0; sr1 = 0; sr2 = 0; base = 0; idx = 0; segr1 = 0; segr2 = 0;
    sr1_en = 0; sr2_en = 0; base_en = 0; idx_en = 0; segr1_en = 0; segr2_en = 0;
    dst_gpr = 0; dst_gpr_we = 0; dst_seg = 0; dst_seg_we = 0;
    rel_gpr = 0; rel_gpr_v = 0; rel_seg = 0; rel_seg_v = 0;
    ds_stall = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    step();
    step();
    #2;
    cmp("rst_busy", busy, 0);
    cmp("rst_hz", hz_cnt, 0);
    chk_en = 1'b1;
    rst = 1'b1;
    #2;
    cmp("idle_rr_v_in", rr_v_in, 0);
    cmp("idle_dec_stall", dec_stall, 0);

    // RAW on GPR 3
    step();
    d_v = 1; dst_gpr = 3; dst_gpr_we = 1;
    #2 cmp("raw_prod_issue", rr_v_in, 1);
    step();
    dst_gpr_we = 0; sr1 = 3; sr1_en = 1;
    #2;
    cmp("raw_busy", busy, 1);
    cmp("raw_stall", dec_stall, 1);
    cmp("raw_bubble", rr_v_in, 0);
    step();
    #2 cmp("raw_hz1", hz_cnt, 1);
    step();
    rel_gpr = 3; rel_gpr_v = 1;
    #2;
    cmp("raw_rel_issue", rr_v_in, BYP);
    cmp("raw_rel_stall", dec_stall, 1 - BYP);
    cmp("raw_hz2", hz_cnt, 2);
    step();
    rel_gpr_v = 0; d_v = (BYP == 0);
    #2;
    cmp("raw_late_issue", rr_v_in, 1 - BYP);
    cmp("raw_hz_total", hz_cnt, 2 + (1 - BYP));
    step();
    idle();
    #2 cmp("raw_busy_clear", busy, 0);

    // Saturation on segment 2
    d_v = 1; dst_seg = 2; dst_seg_we = 1;
    for (int i = 0; i < 3; i++) begin
      #2 cmp("sat_fill_issue", rr_v_in, 1);
      step();
    end
    #2;
    cmp("sat_model_cnt", sm[2], 3);
    cmp("sat_stall", dec_stall, 1);
    cmp("sat_bubble", rr_v_in, 0);
    step();
    rel_seg = 2; rel_seg_v = 1;
    #2 cmp("sat_rel_cycle", rr_v_in, 0);
    step();
    rel_seg_v = 0;
    #2 cmp("sat_issue_after_rel", rr_v_in, 1);
    step();
    d_v = 0; dst_seg_we = 0; rel_seg = 2; rel_seg_v = 1;
    #2;
    cmp("sat_dut_cnt", dut.scnt_q[2], 3);
    cmp("sat_hz", hz_cnt, 4 + (1 - BYP));
    step();
    step();
    step();
    rel_seg_v = 0;

    // Downstream stall with an independent instruction
    d_v = 1; dst_gpr = 1; dst_gpr_we = 1; ds_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      cmp("ds_rr_stall", rr_stall, 1);
      cmp("ds_dec_stall", dec_stall, 1);
      cmp("ds_bubble", rr_v_in, 0);
      cmp("ds_hz_hold", hz_cnt, 4 + (1 - BYP));
      cmp("ds_busy", busy, 0);
      step();
    end
    ds_stall = 0;
    #2 cmp("ds_release_issue", rr_v_in, 1);
    step();
    idle();
    rel_gpr = 1; rel_gpr_v = 1;
    #2 cmp("ds_busy_after", busy, 1);
    step();
    rel_gpr_v = 0;
    #2 cmp("ds_busy_clear", busy, 0);

    // Flush squashes the decoded writer
    d_v = 1; dst_gpr = 4; dst_gpr_we = 1; flush = 1;
    #2;
    cmp("flush_rr_v_in", rr_v_in, 0);
    cmp("flush_dec_stall", dec_stall, 0);
    step();
    idle();
    #2;
    cmp("flush_busy", busy, 0);
    cmp("flush_dut_cnt", dut.gcnt_q[4], 0);
    cmp("flush_model_cnt", gm[4], 0);

    // Simultaneous issue/release on GPR 5, then reset with writes in flight
    d_v = 1; dst_gpr = 5; dst_gpr_we = 1;
    step();
    rel_gpr = 5; rel_gpr_v = 1;
    #2 cmp("simul_issue", rr_v_in, 1);
    step();
    rel_gpr_v = 0; d_v = 0; dst_gpr_we = 0;
    #2;
    cmp("simul_dut_cnt", dut.gcnt_q[5], 1);
    cmp("simul_busy", busy, 1);
    d_v = 1; dst_gpr = 6; dst_gpr_we = 1;
    step();
    idle();
    rst = 0;
    #2;
    step();
    rst = 1;
    #2;
    cmp("mid_rst_busy", busy, 0);
    cmp("mid_rst_hz", hz_cnt, 0);
    cmp("mid_rst_g5", dut.gcnt_q[5], 0);
    cmp("mid_rst_g6", dut.gcnt_q[6], 0);

    // Long hazard on GPR 7 drives hz_cnt into saturation
    d_v = 1; dst_gpr = 7; dst_gpr_we = 1;
    step();
    dst_gpr_we = 0; sr2 = 7; sr2_en = 1;
    repeat (20) step();
    #2;
    cmp("hz_saturate", hz_cnt, HZMAX);
    cmp("hz_sat_stall", dec_stall, 1);
    rel_gpr = 7; rel_gpr_v = 1;
    step();
    rel_gpr_v = 0; d_v = (BYP == 0);
    step();
    idle();
    step();
    #2 cmp("end_busy", busy, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
